// File: rtl/hex_keypad_entry_if.sv
// Keypad entry bus: keypad matrix lines, clear request and entered-value outputs.
// The slave modport is the keypad scanner. The master modport is whoever
// drives the keypad lines and consumes the entered value.
interface hex_keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [31:0] value;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [3:0]  digit_count;

    modport slave (
        input  row,
        input  clear,
        output col,
        output value,
        output key_valid,
        output key_code,
        output digit_count
    );

    modport master (
        output row,
        output clear,
        input  col,
        input  value,
        input  key_valid,
        input  key_code,
        input  digit_count
    );
endinterface

// File: rtl/hex_keypad_entry.sv
// Hex keypad scanner: drives the columns of a 4x4 matrix one at a time and
// samples the synchronised rows once per column dwell. At the end of each full
// scan it classifies the scan and feeds a debounce FSM. Every accepted key is
// shifted into an 8-nibble value, with the newest digit in nibble 0.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 150000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    hex_keypad_entry_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_SCANS);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] HELD     = 2'd2;

    logic [3:0]    rowMeta_q, rowSync_q;
    logic [PW-1:0] prescaler_q;
    logic [1:0]    colIdx_q;
    logic [11:0]   snap_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [31:0]   value_q, value_d;
    logic          keyValid_q;
    logic [3:0]    keyCode_q;
    logic [3:0]    digitCount_q, digitCount_d;

    logic          tick, scanEnd, accept;
    logic [15:0]   scanBits;
    logic [4:0]    hitCount;
    logic [3:0]    scanCode;
    logic          isNone, isSingle;

    assign tick     = (prescaler_q == PRESC_MAX);
    assign scanEnd  = tick && (colIdx_q == 2'd3);
    // Column 3 is never stored: it is taken live from the synchroniser on the scan-end tick.
    assign scanBits = {~rowSync_q, snap_q};
    assign isNone   = (scanBits == 16'h0000);
    assign isSingle = (hitCount == 5'd1);

    // Two-flop synchroniser for the asynchronous, active-low row lines
    always_ff @(posedge clk) begin
        if (rst) begin
            rowMeta_q <= 4'hF;
            rowSync_q <= 4'hF;
        end else begin
            rowMeta_q <= bus.row;
            rowSync_q <= rowMeta_q;
        end
    end

    // Column dwell prescaler, column stepping and per-column row capture
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler_q <= '0;
            colIdx_q    <= 2'd0;
            snap_q      <= '0;
        end else begin
            if (tick) begin
                prescaler_q <= '0;
                colIdx_q    <= colIdx_q + 2'd1;
                case (colIdx_q)
                    2'd0:    snap_q[3:0]  <= ~rowSync_q;
                    2'd1:    snap_q[7:4]  <= ~rowSync_q;
                    2'd2:    snap_q[11:8] <= ~rowSync_q;
                    default: snap_q       <= snap_q;
                endcase
            end else begin
                prescaler_q <= prescaler_q + PW'(1);
            end
        end
    end

    // Count pressed positions in the scan and encode the highest one as {col,row}
    always_comb begin
        hitCount = 5'd0;
        scanCode = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (scanBits[i]) begin
                hitCount = hitCount + 5'd1;
                scanCode = 4'(i);
            end
        end
    end

    // Debounce FSM: it advances only on scan-end ticks; a multi-key scan never qualifies as a press
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        accept  = 1'b0;
        if (scanEnd) begin
            case (state_q)
                IDLE: begin
                    if (isSingle) begin
                        cand_d = scanCode;
                        if (DEB_TARGET == CW'(1)) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (isSingle && (scanCode == cand_q)) begin
                        if (cnt_q + CW'(1) == DEB_TARGET) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                            rel_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (isNone) begin
                        if (rel_q + CW'(1) == DEB_TARGET) begin
                            state_d = IDLE;
                            rel_d   = '0;
                        end else begin
                            rel_d = rel_q + CW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = '0;
                end
            endcase
        end
    end

    // Entered value and digit count: clear takes effect first, then any accepted digit is shifted in
    always_comb begin
        value_d      = bus.clear ? 32'h0 : value_q;
        digitCount_d = bus.clear ? 4'd0 : digitCount_q;
        if (accept) begin
            value_d = {value_d[27:0], scanCode};
            if (digitCount_d < 4'd8) begin
                digitCount_d = digitCount_d + 4'd1;
            end
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cand_q       <= 4'h0;
            cnt_q        <= '0;
            rel_q        <= '0;
            value_q      <= 32'h0;
            keyValid_q   <= 1'b0;
            keyCode_q    <= 4'h0;
            digitCount_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            rel_q        <= rel_d;
            value_q      <= value_d;
            keyValid_q   <= accept;
            digitCount_q <= digitCount_d;
            if (accept) begin
                keyCode_q <= scanCode;
            end
        end
    end

    assign bus.col         = ~(4'b0001 << colIdx_q);
    assign bus.value       = value_q;
    assign bus.key_valid   = keyValid_q;
    assign bus.key_code    = keyCode_q;
    assign bus.digit_count = digitCount_q;
endmodule
